superposition: RTL and testbench

- Mixes eight simultaneous 16-bit signed voice samples (one per active piano note) into a single 16-bit output sample by averaging them (sum, then divide by 8).
- Sits between the per-note waveform generators and the audio DAC/codec path.
- Uses a request/ready handshake with the upstream generators, one request per output sample.

---
 rtl/superposition.sv | 87 ++++++++
 tb/tb_superposition.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/superposition.sv
// superposition: averages NUM_VOICES signed voice samples into one output
// sample. Voices are captured in one cycle, summed serially (one voice per
// cycle) into a widened accumulator, then divided by an arithmetic shift.
module superposition #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 16,
    parameter int SHIFT      = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] samples,
    input  logic                           new_sample_ready,
    output logic                           generate_new_sample,
    output logic [SAMPLE_W-1:0]            out_sample
);

    localparam int ACC_W = SAMPLE_W + SHIFT;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                           state;
    logic [NUM_VOICES*SAMPLE_W-1:0]   voice_buf;
    logic signed [ACC_W-1:0]          acc;
    logic [SHIFT-1:0]                 idx;
    logic signed [SAMPLE_W-1:0]       cur_voice;
    logic signed [ACC_W-1:0]          cur_voice_ext;

    // Select the voice addressed by idx from the captured set and sign-extend it.
    always_comb begin
        cur_voice     = voice_buf[idx*SAMPLE_W +: SAMPLE_W];
        cur_voice_ext = ACC_W'(cur_voice);
    end

    // Request/capture/accumulate/publish sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the capture buffer and accumulator are cleared on reset too,
            // so an aborted mix can never leak a partial sum into a later one.
            state               <= REQ;
            generate_new_sample <= 1'b1;
            out_sample          <= '0;
            acc                 <= '0;
            idx                 <= '0;
            voice_buf           <= '0;
        end else begin
            // NOTE: all state updates are non-blocking so every branch reads
            // the pre-edge values of acc/idx/state.
            case (state)
                REQ: begin
                    state               <= WAIT;
                    generate_new_sample <= 1'b0;
                end
                WAIT: begin
                    if (new_sample_ready) begin
                        voice_buf <= samples;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc + cur_voice_ext;
                    idx <= idx + 1'b1;
                    if (idx == SHIFT'(NUM_VOICES - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Arithmetic shift: floor division by NUM_VOICES.
                    out_sample          <= acc[ACC_W-1:SHIFT];
                    state               <= REQ;
                    generate_new_sample <= 1'b1;
                end
                default: begin
                    state               <= REQ;
                    generate_new_sample <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_superposition.sv
// Testbench for superposition: directed voice sets with hand-computed averages.
// Expected outputs are queued at issue time; a monitor pops and compares them
// whenever the DUT raises generate_new_sample (out_sample is fresh then).
module tb_superposition;

    logic         clk;
    logic         rst;
    logic [127:0] samples;
    logic         new_sample_ready;
    logic         generate_new_sample;
    logic [15:0]  out_sample;

    int           n_checks;
    int           n_errors;
    logic [15:0]  sb[$];
    logic [15:0]  last_exp;

    superposition dut (
        .clk                 (clk),
        .rst                 (rst),
        .samples             (samples),
        .new_sample_ready    (new_sample_ready),
        .generate_new_sample (generate_new_sample),
        .out_sample          (out_sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: each request cycle out of reset presents a finished output.
    always @(negedge clk) begin
        if (rst === 1'b0 && generate_new_sample === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_sample);
            end else begin
                check("out_sample", {16'h0, out_sample}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Issue one voice set from WAIT, scramble inputs during ACC, time the result.
    task automatic send(input logic [127:0] v, input logic [15:0] exp);
        int cnt;
        sb.push_back(exp);
        last_exp         = exp;
        samples          = v;
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        samples          = ~v;
        cnt = 0;
        while (generate_new_sample !== 1'b1 && cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency", cnt, 9);
        @(posedge clk); #1;
    endtask

    initial begin
        int gen_count;
        int pulses;
        int cyc;
        int pulse_at[3];

        n_checks         = 0;
        n_errors         = 0;
        rst              = 1'b1;
        samples          = '0;
        new_sample_ready = 1'b0;
        last_exp         = 16'h0;

        // Reset: two cycles, then one request cycle with out_sample = 0.
        sb.push_back(16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("gen_after_reset", {31'h0, generate_new_sample}, 32'd1);
        @(posedge clk); #1;
        check("gen_in_wait", {31'h0, generate_new_sample}, 32'd0);

        // Directed averaging vectors.
        send(128'd128, 16'h0010);
        send(128'd100, 16'h000C);
        send(128'h00100020004000800100020004000800, 16'h01FE);
        send({8{16'h7FFF}}, 16'h7FFF);
        send({8{16'h8000}}, 16'h8000);
        send(128'h0000000000000000000000000000FFFF, 16'hFFFF);
        send(128'h0000000000000000000000000000FFE00010 >> 0, 16'hFFFE);

        // Idle: ready low for 20 cycles, no request, output held.
        gen_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (generate_new_sample === 1'b1) gen_count++;
        end
        check("idle_no_request", gen_count, 0);
        check("idle_hold", {16'h0, out_sample}, {16'h0, last_exp});

        // Continuous ready: a request every 11 cycles.
        for (int i = 0; i < 3; i++) sb.push_back(16'h1234);
        last_exp         = 16'h1234;
        samples          = {8{16'h1234}};
        new_sample_ready = 1'b1;
        pulses = 0;
        cyc    = 0;
        while (pulses < 3 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (generate_new_sample === 1'b1) begin
                pulse_at[pulses] = cyc;
                pulses++;
                if (pulses == 3) new_sample_ready = 1'b0;
            end
        end
        new_sample_ready = 1'b0;
        check("stream_pulses", pulses, 3);
        if (pulses == 3) begin
            check("stream_period_1", pulse_at[1] - pulse_at[0], 11);
            check("stream_period_2", pulse_at[2] - pulse_at[1], 11);
        end
        @(posedge clk); #1;

        // Reset four cycles after capture aborts the mix.
        samples          = {8{16'h0700}};
        new_sample_ready = 1'b1;
        @(posedge clk); #1;
        new_sample_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back(16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_gen", {31'h0, generate_new_sample}, 32'd1);
        check("midreset_out", {16'h0, out_sample}, 32'h0);
        @(posedge clk); #1;
        check("midreset_wait", {31'h0, generate_new_sample}, 32'd0);
        send(128'd128, 16'h0010);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
